rsa_data_loader: RTL and testbench
==================================

Name: rsa_data_loader

Overview:
- Upstream feeder for the pipelined RSA CPU subsystem.
- Accepts a byte stream from a host interface (valid/ready) and packs bytes into 32-bit little-endian words.
- Writes the words into the data memory starting at a base address, then pulses the CPU start input and tracks completion through EndFlag.
- While loading, it owns the data-memory write port through mem_sel; the top-level mux honours mem_sel.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word written.
- NUM_WORDS, 4, number of 32-bit words per load (1..255).
- ADDR_STEP, 4, byte increment between consecutive word addresses.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- load_en  input  1  single-cycle request to begin a load; sampled only in IDLE or DONE.
- in_valid  input  1  host byte valid.
- in_data  input  8  host byte.
- in_ready  output  1  loader accepts in_data this cycle (transfer = in_valid & in_ready).
- mem_sel  output  1  loader owns the data-memory port.
- mem_we  output  1  data-memory write enable.
- mem_addr  output  32  data-memory byte address.
- mem_wdata  output  32  data-memory write data.
- start  output  1  one-cycle start pulse to the CPU.
- EndFlag  input  1  CPU program-complete flag.
- busy  output  1  high in LOAD, WRITE, START and RUN.
- done  output  1  high in DONE.

Behaviour:
- Reset is asynchronous and active-high.
  - State goes to IDLE; byte count and word count go to 0; the shift register goes to 0.
  - All outputs are 0, and mem_addr equals BASE_ADDR.
- States are IDLE, LOAD, WRITE, START, RUN, DONE.
- IDLE:
  - in_ready = 0.
  - load_en moves to LOAD and clears the word counter, byte counter and shift register.
- LOAD:
  - mem_sel = 1, in_ready = 1.
  - On each transfer, byte k (k = 0..3) is stored into word bits [8k+7:8k]. The first byte is the LSB.
  - On the 4th transfer, move to WRITE next cycle.
  - in_valid low holds the state with no change.
- WRITE (exactly 1 cycle):
  - mem_sel = 1, mem_we = 1, in_ready = 0.
  - mem_wdata = packed word; mem_addr = BASE_ADDR + word_cnt*ADDR_STEP (32-bit modular arithmetic).
  - The word counter increments at the end of the cycle.
  - If the incremented count equals NUM_WORDS, go to START; else go back to LOAD with the byte counter cleared.
- START (exactly 1 cycle):
  - start = 1, mem_sel = 0.
  - Next state is RUN.
- RUN:
  - mem_sel = 0, in_ready = 0; the CPU owns memory.
  - EndFlag = 1 moves to DONE. EndFlag is ignored in every other state.
- DONE:
  - done = 1 and holds.
  - load_en returns to LOAD with counters cleared. done drops the cycle LOAD is entered.
- Outputs outside their active state:
  - mem_we and start are 0 outside WRITE and START respectively.
  - mem_wdata is don't-care when mem_we = 0.
  - mem_addr shows the next write address whenever mem_sel = 1.
- load_en is ignored in LOAD, WRITE, START and RUN.
- Host bytes presented while in_ready = 0 are not consumed; the host must hold them.
- There is no partial-word flush; a load is complete only after NUM_WORDS*4 bytes.
- Reset asserted mid-load or mid-run aborts immediately: no further mem_we or start, and outputs are forced to their reset values.
- All outputs are registered or decoded purely from state; there are no combinational paths from in_valid to in_ready.
- Latency from the last byte accepted to the start pulse is 2 cycles (WRITE, then START).

Test Plan:
- Reset, then load_en, then 16 bytes 0x01..0x10 with in_valid held high. Required:
  - Four mem_we pulses at addresses 0x0, 0x4, 0x8, 0xC.
  - Write data 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D.
  - start pulses 2 cycles after byte 16.
- Same stream with in_valid toggling every other cycle. Required: identical writes and data; in_ready low in each WRITE cycle; no bytes lost or duplicated.
- Full load completed, then EndFlag held 0 for 20 cycles, then asserted. Required:
  - busy = 1 and done = 0 during the wait.
  - done = 1 the cycle after EndFlag; mem_sel = 0 throughout RUN.
- load_en pulsed while in LOAD and while in RUN. Required: ignored, with counters and addresses unchanged.
- Reset asserted after 6 bytes (mid second word). Required:
  - mem_we, start and busy go to 0 asynchronously.
  - A new load after reset begins at BASE_ADDR with an empty shift register.
- BASE_ADDR = 32'hFFFF_FFF8, NUM_WORDS = 3. Required: addresses wrap to 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000. Then DONE followed by load_en restarts a second load correctly.

Source files
------------

// File: rtl/rsa_data_loader.sv
// rsa_data_loader: packs host bytes into little-endian 32-bit words, writes them
// into data memory, then pulses the CPU start and waits for EndFlag.
module rsa_data_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned NUM_WORDS = 4,
  parameter int unsigned ADDR_STEP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_en,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_sel,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        start,
  input  logic        EndFlag,
  output logic        busy,
  output logic        done
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned BCNT_W = 2;

  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(NUM_WORDS);
  localparam logic [WORD_W-1:0] STEP      = WORD_W'(ADDR_STEP);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    START = 3'd3,
    RUN   = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t              state, state_d;
  logic [BCNT_W-1:0]   byte_cnt, byte_cnt_d;
  logic [CNT_W-1:0]    word_cnt, word_cnt_d;
  logic [WORD_W-1:0]   shift_d;
  logic [WORD_W-1:0]   addr_d;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state and datapath next values; in_ready is a decoded register, so
  // a transfer is LOAD-state and in_valid.
  always_comb begin
    state_d    = state;
    byte_cnt_d = byte_cnt;
    word_cnt_d = word_cnt;
    shift_d    = mem_wdata;
    addr_d     = mem_addr;
    case (state)
      IDLE, DONE: begin
        if (load_en) begin
          state_d    = LOAD;
          byte_cnt_d = '0;
          word_cnt_d = '0;
          shift_d    = '0;
          addr_d     = BASE_ADDR;
        end
      end
      LOAD: begin
        if (in_valid) begin
          shift_d[{byte_cnt, 3'b000} +: 8] = in_data;
          byte_cnt_d = byte_cnt + BCNT_W'(1);
          if (byte_cnt == BCNT_W'(3)) state_d = WRITE;
        end
      end
      WRITE: begin
        word_cnt_d = word_cnt + CNT_W'(1);
        addr_d     = mem_addr + STEP;
        byte_cnt_d = '0;
        if (word_cnt + CNT_W'(1) == LAST_WORD) state_d = START;
        else                                   state_d = LOAD;
      end
      START: state_d = RUN;
      RUN: begin
        if (EndFlag) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters, packed word and next write address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt  <= '0;
      word_cnt  <= '0;
      mem_wdata <= '0;
      mem_addr  <= BASE_ADDR;
    end else begin
      byte_cnt  <= byte_cnt_d;
      word_cnt  <= word_cnt_d;
      mem_wdata <= shift_d;
      mem_addr  <= addr_d;
    end
  end

  // Control outputs registered from the next state so they track state exactly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready <= 1'b0;
      mem_sel  <= 1'b0;
      mem_we   <= 1'b0;
      start    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      in_ready <= (state_d == LOAD);
      mem_sel  <= (state_d == LOAD) || (state_d == WRITE);
      mem_we   <= (state_d == WRITE);
      start    <= (state_d == START);
      busy     <= (state_d == LOAD) || (state_d == WRITE) ||
                  (state_d == START) || (state_d == RUN);
      done     <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_rsa_data_loader.sv
// Bench for rsa_data_loader: default instance (base 0, 4 words) and a wrapping
// instance (base 0xFFFFFFF8, 3 words) sharing host/CPU inputs.
module tb_rsa_data_loader;

  localparam logic [31:0] BASE_A = 32'h0000_0000;
  localparam logic [31:0] BASE_B = 32'hFFFF_FFF8;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int          mode;    // 0 valid held, 1 toggling, 2 random
    logic [7:0]  first;   // first byte, stream increments by 1
    int          le_at;   // byte index at which load_en is pulsed (-1 none)
    logic [31:0] exp [4];
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic load_en_a, load_en_b, in_valid, EndFlag;
  logic [7:0] in_data;

  logic a_in_ready, a_mem_sel, a_mem_we, a_start, a_busy, a_done;
  logic [31:0] a_mem_addr, a_mem_wdata;
  logic b_in_ready, b_mem_sel, b_mem_we, b_start, b_busy, b_done;
  logic [31:0] b_mem_addr, b_mem_wdata;

  rsa_data_loader u_a (
    .clk(clk), .reset(reset), .load_en(load_en_a), .in_valid(in_valid),
    .in_data(in_data), .in_ready(a_in_ready), .mem_sel(a_mem_sel),
    .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .start(a_start), .EndFlag(EndFlag), .busy(a_busy), .done(a_done)
  );

  rsa_data_loader #(.BASE_ADDR(BASE_B), .NUM_WORDS(3), .ADDR_STEP(4)) u_b (
    .clk(clk), .reset(reset), .load_en(load_en_b), .in_valid(in_valid),
    .in_data(in_data), .in_ready(b_in_ready), .mem_sel(b_mem_sel),
    .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .start(b_start), .EndFlag(EndFlag), .busy(b_busy), .done(b_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int sel = 0;
  wr_t qa[$], qb[$];
  int start_cnt_a = 0, start_cnt_b = 0, start_cyc_a = 0, start_cyc_b = 0;
  int viol_a = 0, viol_b = 0;
  logic [7:0]  stim[$];
  logic [31:0] exp_w[$];
  int exp_starts_a = 0, exp_starts_b = 0;
  vec_t vec [3];

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor: capture writes and start pulses of both instances
  always @(negedge clk) begin
    if (a_mem_we) begin
      qa.push_back('{a_mem_addr, a_mem_wdata});
      if (a_in_ready || !a_mem_sel) viol_a++;
    end
    if (b_mem_we) begin
      qb.push_back('{b_mem_addr, b_mem_wdata});
      if (b_in_ready || !b_mem_sel) viol_b++;
    end
    if (a_start) begin start_cnt_a++; start_cyc_a = cyc; end
    if (b_start) begin start_cnt_b++; start_cyc_b = cyc; end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic c_ready();  return sel != 0 ? b_in_ready : a_in_ready; endfunction
  function automatic logic c_busy();   return sel != 0 ? b_busy     : a_busy;     endfunction
  function automatic logic c_done();   return sel != 0 ? b_done     : a_done;     endfunction
  function automatic logic c_memsel(); return sel != 0 ? b_mem_sel  : a_mem_sel;  endfunction
  function automatic logic c_memwe();  return sel != 0 ? b_mem_we   : a_mem_we;   endfunction

  task automatic set_le(input logic v);
    if (sel != 0) load_en_b = v;
    else          load_en_a = v;
  endtask

  // Reference model: little-endian packing of the byte stream
  task automatic model_words();
    exp_w.delete();
    for (int i = 0; i < stim.size() / 4; i++)
      exp_w.push_back(32'(stim[4*i]) + (32'(stim[4*i+1]) << 8) +
                      (32'(stim[4*i+2]) << 16) + (32'(stim[4*i+3]) << 24));
  endtask

  // Present stim[] to the host port; a byte advances only when in_ready was high
  task automatic feed(input int mode, input int le_at, output int last_acc);
    int idx = 0;
    int k = 0;
    int guard = 0;
    last_acc = -1;
    while (idx < stim.size() && guard < 2000) begin
      @(negedge clk);
      guard++;
      set_le(1'b0);
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (k % 2 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      k++;
      in_data = stim[idx];
      if (le_at >= 0 && idx == le_at) set_le(1'b1);
      if (in_valid && c_ready()) begin
        last_acc = cyc;
        idx++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    set_le(1'b0);
    chk("feed_bytes_consumed", 32'(idx), 32'(stim.size()));
  endtask

  // One complete load: request, stream, then check writes and start timing
  task automatic do_load(input int mode, input int le_at);
    int last;
    int nw;
    logic [31:0] base;
    wr_t got[$];
    nw   = (sel != 0) ? 3 : 4;
    base = (sel != 0) ? BASE_B : BASE_A;
    qa.delete();
    qb.delete();
    viol_a = 0;
    viol_b = 0;
    @(negedge clk);
    set_le(1'b1);
    feed(mode, le_at, last);
    repeat (3) @(negedge clk);
    #1;
    got = (sel != 0) ? qb : qa;
    chk("num_writes", 32'(got.size()), 32'(nw));
    for (int i = 0; i < nw && i < got.size(); i++) begin
      chk($sformatf("wr%0d_addr", i), got[i].addr, base + 32'(i) * 32'd4);
      chk($sformatf("wr%0d_data", i), got[i].data, exp_w[i]);
    end
    chk("ready_low_in_write", 32'((sel != 0) ? viol_b : viol_a), 32'd0);
    if (sel != 0) begin
      exp_starts_b++;
      chk("start_count", 32'(start_cnt_b), 32'(exp_starts_b));
      chk("start_latency", 32'(start_cyc_b - last), 32'd2);
    end else begin
      exp_starts_a++;
      chk("start_count", 32'(start_cnt_a), 32'(exp_starts_a));
      chk("start_latency", 32'(start_cyc_a - last), 32'd2);
    end
  endtask

  // Hold EndFlag low (with a stray load_en), then complete the run
  task automatic finish_run(input int wait_n);
    int bad = 0;
    int nw;
    nw = (sel != 0) ? 3 : 4;
    EndFlag = 1'b0;
    for (int i = 0; i < wait_n; i++) begin
      @(negedge clk);
      set_le(i == 5);
      if (!c_busy() || c_done() || c_memsel() || c_memwe()) bad++;
    end
    set_le(1'b0);
    chk("run_wait_bad_cycles", 32'(bad), 32'd0);
    chk("run_no_extra_writes", 32'((sel != 0) ? qb.size() : qa.size()), 32'(nw));
    chk("run_no_extra_start", 32'((sel != 0) ? start_cnt_b : start_cnt_a),
        32'((sel != 0) ? exp_starts_b : exp_starts_a));
    @(negedge clk);
    EndFlag = 1'b1;
    @(negedge clk);
    EndFlag = 1'b0;
    chk("done_after_endflag", 32'(c_done()), 32'd1);
    chk("busy_after_endflag", 32'(c_busy()), 32'd0);
    @(negedge clk);
    chk("done_holds", 32'(c_done()), 32'd1);
  endtask

  task automatic incr_stream(input logic [7:0] first, input int n);
    logic [7:0] b;
    stim.delete();
    b = first;
    for (int i = 0; i < n; i++) begin
      stim.push_back(b);
      b = b + 8'd1;
    end
  endtask

  task automatic rand_stream(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    vec[0] = '{0, 8'h01, -1, '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D}};
    vec[1] = '{1, 8'h01, -1, '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D}};
    vec[2] = '{2, 8'h11,  5, '{32'h14131211, 32'h18171615, 32'h1C1B1A19, 32'h201F1E1D}};

    reset = 1'b1;
    load_en_a = 1'b0;
    load_en_b = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    EndFlag = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_a_addr", a_mem_addr, BASE_A);
    chk("rst_b_addr", b_mem_addr, BASE_B);
    chk("rst_a_ctrl", {26'd0, a_in_ready, a_mem_sel, a_mem_we, a_start, a_busy, a_done}, 32'd0);
    chk("rst_b_ctrl", {26'd0, b_in_ready, b_mem_sel, b_mem_we, b_start, b_busy, b_done}, 32'd0);
    chk("rst_a_wdata", a_mem_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ready_low", 32'(a_in_ready), 32'd0);

    // Table-driven loads on the default instance
    sel = 0;
    for (int v = 0; v < 3; v++) begin
      incr_stream(vec[v].first, 16);
      exp_w.delete();
      for (int i = 0; i < 4; i++) exp_w.push_back(vec[v].exp[i]);
      do_load(vec[v].mode, vec[v].le_at);
      finish_run(20);
    end

    // Randomized loads against the packing model
    for (int r = 0; r < 4; r++) begin
      rand_stream(16);
      model_words();
      do_load(2, -1);
      finish_run(8 + r);
    end

    // Reset in the middle of the second word
    incr_stream(8'h01, 6);
    @(negedge clk);
    load_en_a = 1'b1;
    begin
      int last;
      feed(0, -1, last);
    end
    chk("midload_busy_before", 32'(a_busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_ctrl", {26'd0, a_in_ready, a_mem_sel, a_mem_we, a_start, a_busy, a_done}, 32'd0);
    chk("abort_addr", a_mem_addr, BASE_A);
    chk("abort_wdata", a_mem_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_starts_a = 0;
    start_cnt_a = 0;
    exp_starts_b = 0;
    start_cnt_b = 0;
    incr_stream(8'h01, 16);
    model_words();
    do_load(1, -1);
    finish_run(10);

    // Wrapping instance: two back-to-back loads, the second from DONE
    sel = 1;
    rand_stream(12);
    model_words();
    do_load(1, -1);
    chk("wrap_third_addr", (qb.size() > 2) ? qb[2].addr : 32'hDEAD_BEEF, 32'h0000_0000);
    finish_run(6);
    incr_stream(8'hA0, 12);
    exp_w.delete();
    exp_w.push_back(32'hA3A2A1A0);
    exp_w.push_back(32'hA7A6A5A4);
    exp_w.push_back(32'hABAAA9A8);
    do_load(0, 3);
    finish_run(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
